// File: rtl/afpw_pkg.sv
// Shared types and constants for the AXI frame pattern writer.
package afpw_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StFdone
    } afpw_state_e;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_GRAD  = 2'd2;
    localparam logic [1:0] PAT_CHK   = 2'd3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Framebuffer pixel layout is {A,R,B,G}.
    function automatic logic [31:0] pix_word(logic [7:0] r, logic [7:0] g, logic [7:0] b);
        return {8'hFF, r, b, g};
    endfunction

endpackage

// File: rtl/afpw_pixel_gen.sv
// Pattern generator: tracks x/y/bar position and registers one AXI beat of pixels,
// prepared ahead so the next beat is ready on the cycle after a handshake.
module afpw_pixel_gen
    import afpw_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PIX_BYTES = 4,
    parameter int unsigned FRAME_W   = 1920,
    parameter int unsigned CHK_SHIFT = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [1:0]        mode_i,
    input  logic [23:0]       rgb_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned PIX_W = 8 * PIX_BYTES;
    localparam int unsigned PPB   = DATA_W / PIX_W;
    localparam int unsigned CW    = 16;
    localparam logic [CW-1:0] BAR_PIX  = CW'(FRAME_W / 8);
    localparam logic [CW-1:0] LINE_PIX = CW'(FRAME_W);

    logic [CW-1:0]     x_q, y_q, nb_q;
    logic [2:0]        bar_q;
    logic [1:0]        mode_q;
    logic [23:0]       rgb_q;
    logic [DATA_W-1:0] data_q;

    logic [CW-1:0]     x_d, y_d, nb_d;
    logic [2:0]        bar_d;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        mode_c;
    logic [23:0]       rgb_c;
    logic [CW-1:0]     px, bnd;
    logic [2:0]        bar_c;
    logic [7:0]        r, g, bl;

    always_comb begin
        mode_c = start_i ? mode_i : mode_q;
        rgb_c  = start_i ? rgb_i : rgb_q;

        // Bar tracking: nb is the first column of the next bar, so no divider is needed.
        x_d   = x_q + CW'(PPB);
        y_d   = y_q;
        bar_d = bar_q;
        nb_d  = nb_q;
        for (int unsigned i = 1; i <= PPB; i++) begin
            if (x_q + CW'(i) >= nb_d) begin
                bar_d = bar_d + 3'd1;
                nb_d  = nb_d + BAR_PIX;
            end
        end
        if (x_d == LINE_PIX) begin
            x_d   = '0;
            y_d   = y_q + CW'(1);
            bar_d = '0;
            nb_d  = BAR_PIX;
        end
        if (start_i) begin
            x_d   = '0;
            y_d   = '0;
            bar_d = '0;
            nb_d  = BAR_PIX;
        end

        bar_c  = bar_d;
        bnd    = nb_d;
        px     = '0;
        r      = '0;
        g      = '0;
        bl     = '0;
        data_d = '0;
        for (int unsigned i = 0; i < PPB; i++) begin
            px = x_d + CW'(i);
            if (px >= bnd) begin
                bar_c = bar_c + 3'd1;
                bnd   = bnd + BAR_PIX;
            end
            unique case (mode_c)
                PAT_SOLID: {r, g, bl} = rgb_c;
                PAT_BARS:  {r, g, bl} = {{8{bar_c[2]}}, {8{bar_c[1]}}, {8{bar_c[0]}}};
                PAT_GRAD:  {r, g, bl} = {px[7:0], y_d[7:0], 8'h80};
                PAT_CHK:   {r, g, bl} = (px[CHK_SHIFT] ^ y_d[CHK_SHIFT]) ? ~rgb_c : rgb_c;
                default:   {r, g, bl} = rgb_c;
            endcase
            data_d[i*PIX_W +: PIX_W] = PIX_W'(pix_word(r, g, bl));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q    <= '0;
            y_q    <= '0;
            nb_q   <= BAR_PIX;
            bar_q  <= '0;
            mode_q <= PAT_SOLID;
            rgb_q  <= '0;
            data_q <= '0;
        end else if (start_i || advance_i) begin
            x_q    <= x_d;
            y_q    <= y_d;
            nb_q   <= nb_d;
            bar_q  <= bar_d;
            data_q <= data_d;
            if (start_i) begin
                mode_q <= mode_i;
                rgb_q  <= rgb_i;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/axi_frame_pattern_writer.sv
// AXI3 write master filling a framebuffer with a test pattern in fixed INCR bursts,
// one burst outstanding at a time.
module axi_frame_pattern_writer
    import afpw_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 64,
    parameter int unsigned        PIX_BYTES  = 4,
    parameter int unsigned        FRAME_W    = 1920,
    parameter int unsigned        FRAME_H    = 1080,
    parameter int unsigned        BURST_LEN  = 16,
    parameter logic [ADDR_W-1:0]  ADDR_START = 32'h1000_0000,
    parameter int unsigned        CHK_SHIFT  = 5
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic [1:0]          pattern_mode,
    input  logic [23:0]         solid_rgb,
    input  logic                err_clr,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [3:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                frame_done,
    output logic                err_sticky,
    output logic [15:0]         frame_count
);

    localparam int unsigned PIX_PER_BEAT = DATA_W / (8 * PIX_BYTES);
    localparam int unsigned BURST_BYTES  = BURST_LEN * DATA_W / 8;
    localparam int unsigned FRAME_BYTES  = FRAME_W * FRAME_H * PIX_BYTES;
    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_START + ADDR_W'(FRAME_BYTES);
    localparam logic [3:0]        LAST_BEAT = 4'(BURST_LEN - 1);

    if (FRAME_BYTES % BURST_BYTES != 0) begin : g_chk_frame
        $error("FRAME_BYTES must be a multiple of BURST_BYTES");
    end
    if (4096 % BURST_BYTES != 0) begin : g_chk_4k
        $error("BURST_BYTES must divide 4096");
    end
    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_chk_len
        $error("BURST_LEN must be 1..16");
    end
    if (PIX_PER_BEAT == 0 || FRAME_W % PIX_PER_BEAT != 0 || FRAME_W % 8 != 0) begin : g_chk_w
        $error("FRAME_W must be a multiple of PIX_PER_BEAT and of 8");
    end

    afpw_state_e       state_q;
    logic [ADDR_W-1:0] addr_q, awaddr_q, next_addr;
    logic [3:0]        beat_q;
    logic              awvalid_q, wvalid_q, wlast_q, bready_q, frame_done_q, err_q;
    logic [15:0]       frame_count_q;
    logic              start, advance;

    assign next_addr = addr_q + ADDR_W'(BURST_BYTES);
    assign start     = (state_q == StIdle) && enable;
    assign advance   = wvalid_q && m_axi_wready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            awaddr_q      <= '0;
            beat_q        <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        addr_q    <= ADDR_START;
                        awaddr_q  <= ADDR_START;
                        awvalid_q <= 1'b1;
                        state_q   <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        wlast_q   <= (BURST_LEN == 1);
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (m_axi_wready) begin
                        beat_q <= beat_q + 4'd1;
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= StResp;
                        end else begin
                            wlast_q <= (beat_q + 4'd1 == LAST_BEAT);
                        end
                    end
                end
                StResp: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        addr_q   <= next_addr;
                        if (next_addr == ADDR_END) begin
                            frame_done_q <= 1'b1;
                            state_q      <= StFdone;
                        end else begin
                            awaddr_q  <= next_addr;
                            awvalid_q <= 1'b1;
                            state_q   <= StAddr;
                        end
                    end
                end
                StFdone: begin
                    frame_done_q  <= 1'b0;
                    frame_count_q <= frame_count_q + 16'd1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // A new error wins over a simultaneous clear.
            if (bready_q && m_axi_bvalid && m_axi_bresp != RESP_OKAY) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    afpw_pixel_gen #(
        .DATA_W   (DATA_W),
        .PIX_BYTES(PIX_BYTES),
        .FRAME_W  (FRAME_W),
        .CHK_SHIFT(CHK_SHIFT)
    ) u_pixel_gen (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start_i  (start),
        .advance_i(advance),
        .mode_i   (pattern_mode),
        .rgb_i    (solid_rgb),
        .data_o   (m_axi_wdata)
    );

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign frame_done    = frame_done_q;
    assign err_sticky    = err_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axi_frame_pattern_writer.sv
// Directed/randomised bench for axi_frame_pattern_writer on a 16x4 frame with a stalling slave.
module tb_axi_frame_pattern_writer;

    localparam int FW = 16, FH = 4, BL = 4, DW = 64, PB = 4, CS = 1;
    localparam int PPB = DW / (8 * PB);
    localparam int NBEATS = FW * FH / PPB;
    localparam int NBURST = NBEATS / BL;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        aclk, aresetn, enable, err_clr;
    logic [1:0]  pattern_mode;
    logic [23:0] solid_rgb;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        frame_done, err_sticky;
    logic [15:0] frame_count;

    int npass = 0, ntot = 0;
    int stab_err = 0, fd_cnt = 0, aw_seen = 0, exp_fc = 0;
    int aw_wait, w_wait, b_wait, b_pend, b_idx, err_burst = -1;
    bit stall = 0, clr_req = 0, clr_coinc = 0, aw_hold = 0, w_hold = 0, wl_prev;
    logic [31:0] aw_prev;
    logic [63:0] w_prev, tmp;
    logic [31:0] aw_q[$];
    logic [63:0] beat_q[$];
    bit          last_q[$];
    int          cur_mode;
    logic [23:0] cur_rgb;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    axi_frame_pattern_writer #(
        .ADDR_W    (32),
        .DATA_W    (DW),
        .PIX_BYTES (PB),
        .FRAME_W   (FW),
        .FRAME_H   (FH),
        .BURST_LEN (BL),
        .ADDR_START(BASE),
        .CHK_SHIFT (CS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .pattern_mode (pattern_mode),
        .solid_rgb    (solid_rgb),
        .err_clr      (err_clr),
        .m_axi_awaddr (awaddr),
        .m_axi_awlen  (awlen),
        .m_axi_awsize (awsize),
        .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wlast  (wlast),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .frame_done   (frame_done),
        .err_sticky   (err_sticky),
        .frame_count  (frame_count)
    );

    // Reference colour of one pixel, straight from the pattern rules.
    function automatic logic [31:0] pix(int mode, logic [23:0] rgb, int x, int y);
        logic [7:0] r, g, b;
        int bar;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        case (mode)
            1: begin
                bar = x / (FW / 8);
                r = ((bar & 4) != 0) ? 8'hFF : 8'h00;
                g = ((bar & 2) != 0) ? 8'hFF : 8'h00;
                b = ((bar & 1) != 0) ? 8'hFF : 8'h00;
            end
            2: begin
                r = 8'(x % 256);
                g = 8'(y % 256);
                b = 8'h80;
            end
            3: if ((((x >> CS) ^ (y >> CS)) & 1) != 0) begin
                r = ~r;
                g = ~g;
                b = ~b;
            end
            default: ;
        endcase
        return {8'hFF, r, b, g};
    endfunction

    function automatic logic [63:0] exp_beat(int k);
        logic [63:0] e;
        int x0, y;
        x0 = (k * PPB) % FW;
        y  = (k * PPB) / FW;
        for (int i = 0; i < PPB; i++) e[i*32 +: 32] = pix(cur_mode, cur_rgb, x0 + i, y);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int rnd();
        return stall ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // One clock of the slave model plus bus monitor, evaluated at the falling edge.
    task automatic cycle();
        @(negedge aclk);
        if (aw_hold && !(awvalid === 1'b1 && awaddr === aw_prev)) stab_err++;
        if (w_hold && !(wvalid === 1'b1 && wdata === w_prev && wlast === wl_prev)) stab_err++;
        if (frame_done === 1'b1) fd_cnt++;
        if (awvalid === 1'b1) aw_seen++;

        awready = awvalid && (aw_wait == 0);
        if (awvalid && aw_wait != 0) aw_wait--;
        wready = wvalid && (w_wait == 0);
        if (wvalid && w_wait != 0) w_wait--;
        bvalid = (b_pend > 0) && (b_wait == 0);
        if (b_pend > 0 && b_wait != 0) b_wait--;
        bresp   = (bvalid && b_idx == err_burst) ? 2'b10 : 2'b00;
        err_clr = clr_req || (clr_coinc && bvalid && bready && bresp != 2'b00);

        if (awvalid && awready) begin
            aw_q.push_back(awaddr);
            aw_wait = rnd();
        end
        if (wvalid && wready) begin
            beat_q.push_back(wdata);
            last_q.push_back(wlast);
            if (wlast) b_pend++;
            w_wait = rnd();
        end
        if (bvalid && bready) begin
            b_pend--;
            b_idx++;
            b_wait = rnd();
        end
        aw_hold = awvalid && !awready;
        aw_prev = awaddr;
        w_hold  = wvalid && !wready;
        w_prev  = wdata;
        wl_prev = wlast;
    endtask

    task automatic start_frame();
        aw_q.delete();
        beat_q.delete();
        last_q.delete();
        aw_hold = 0;
        w_hold  = 0;
        b_pend  = 0;
        b_idx   = 0;
        aw_wait = rnd();
        w_wait  = rnd();
        b_wait  = rnd();
        stab_err = 0;
    endtask

    task automatic set_pat(input int mode, input logic [23:0] rgb);
        cur_mode     = mode;
        cur_rgb      = rgb;
        pattern_mode = 2'(mode);
        solid_rgb    = rgb;
    endtask

    // Run one frame; at stop_at AW handshakes drop enable and scramble the pattern inputs.
    task automatic run_frame(input string tag, input int stop_at);
        int n, fd0, aw0;
        n = 0;
        fd0 = fd_cnt;
        start_frame();
        enable = 1'b1;
        while (fd_cnt == fd0 && n < 3000) begin
            cycle();
            n++;
            if (stop_at > 0 && aw_q.size() >= stop_at && enable) begin
                enable       = 1'b0;
                pattern_mode = ~pattern_mode;
                solid_rgb    = ~solid_rgb;
            end
        end
        enable = 1'b0;
        aw0 = aw_seen;
        repeat (20) cycle();
        exp_fc++;
        chk({tag, "_frame_done_pulses"}, 64'(fd_cnt - fd0), 64'd1);
        chk({tag, "_no_aw_after_stop"}, 64'(aw_seen - aw0), 64'd0);
        chk({tag, "_stable_while_stalled"}, 64'(stab_err), 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
        chk({tag, "_num_bursts"}, 64'(aw_q.size()), 64'(NBURST));
        chk({tag, "_num_beats"}, 64'(beat_q.size()), 64'(NBEATS));
        for (int i = 0; i < NBURST && i < aw_q.size(); i++)
            chk($sformatf("%s_awaddr%0d", tag, i), 64'(aw_q[i]), 64'(BASE + 32'(i * BL * 8)));
        for (int k = 0; k < NBEATS && k < beat_q.size(); k++) begin
            chk($sformatf("%s_wdata%0d", tag, k), beat_q[k], exp_beat(k));
            chk($sformatf("%s_wlast%0d", tag, k), 64'(last_q[k]), 64'((k % BL) == BL - 1));
        end
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        set_pat(0, 24'h123456);
        start_frame();
        repeat (3) cycle();

        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_awaddr", 64'(awaddr), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("awlen", 64'(awlen), 64'd3);
        chk("awsize", 64'(awsize), 64'd3);
        chk("awburst", 64'(awburst), 64'd1);
        chk("wstrb", 64'(wstrb), 64'hFF);
        #2 aresetn = 1'b1;

        // Solid colour, slave always ready.
        run_frame("solid", 0);
        tmp = beat_q[0];
        chk("solid_beat0_const", tmp, 64'hFF125634_FF125634);

        // Gradient with random stalls on every channel.
        stall = 1;
        set_pat(2, 24'($urandom));
        run_frame("grad", 0);
        tmp = beat_q[18];
        chk("grad_pix_x5_y2", 64'(tmp[63:32]), 64'hFF058002);

        // Colour bars.
        set_pat(1, 24'($urandom));
        run_frame("bars", 0);
        tmp = beat_q[0];
        chk("bars_x0", 64'(tmp[31:0]), 64'hFF000000);
        chk("bars_x1", 64'(tmp[63:32]), 64'hFF000000);
        tmp = beat_q[4];
        chk("bars_x8", 64'(tmp[31:0]), 64'hFFFF0000);
        tmp = beat_q[7];
        chk("bars_x14", 64'(tmp[31:0]), 64'hFFFFFFFF);
        chk("bars_x15", 64'(tmp[63:32]), 64'hFFFFFFFF);

        // Checker; enable dropped and inputs scrambled during burst 2.
        set_pat(3, 24'($urandom));
        run_frame("chk_stop", 2);

        // Error response on the third burst, then clear, then clear colliding with an error.
        chk("err_pre", 64'(err_sticky), 64'd0);
        set_pat(0, 24'($urandom));
        err_burst = 2;
        run_frame("err", 0);
        chk("err_set", 64'(err_sticky), 64'd1);
        clr_req = 1;
        cycle();
        clr_req = 0;
        cycle();
        chk("err_cleared", 64'(err_sticky), 64'd0);
        clr_coinc = 1;
        run_frame("err_clr_same", 0);
        chk("err_set_wins", 64'(err_sticky), 64'd1);
        clr_coinc = 0;
        err_burst = -1;

        // Asynchronous reset in the middle of a data burst.
        set_pat(2, 24'($urandom));
        start_frame();
        enable = 1'b1;
        n = 0;
        while (!(beat_q.size() >= 5 && wvalid === 1'b1) && n < 3000) begin
            cycle();
            n++;
        end
        chk("rst_mid_reached", 64'(n < 3000), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_awvalid", 64'(awvalid), 64'd0);
        chk("rst_mid_wvalid", 64'(wvalid), 64'd0);
        chk("rst_mid_bready", 64'(bready), 64'd0);
        chk("rst_mid_frame_done", 64'(frame_done), 64'd0);
        chk("rst_mid_frame_count", 64'(frame_count), 64'd0);
        chk("rst_mid_err", 64'(err_sticky), 64'd0);
        start_frame();
        repeat (3) cycle();
        #2 aresetn = 1'b1;
        exp_fc = 0;
        run_frame("after_rst", 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/axi_frame_pattern_writer.md
Name: axi_frame_pattern_writer

Overview:
Parametrised AXI3 write master that fills a DDR framebuffer with a selectable test pattern, one full frame at a time, in fixed-length INCR bursts. It sits between the PS DDR slave port and the HDMI scan-out path and replaces the fixed single-colour frame generator. Over the previous generator it adds:
- full AW/W/B handshaking with backpressure;
- configurable burst length, data width and pixel packing;
- four pattern modes;
- a frame-done interrupt pulse, error capture and a frame counter.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI data width; multiple of 8*PIX_BYTES
PIX_BYTES, 4, bytes per pixel; pixel word = {8'hFF,R,B,G}
FRAME_W, 1920, pixels per line; multiple of PIX_PER_BEAT and of 8
FRAME_H, 1080, lines per frame
BURST_LEN, 16, beats per burst, 1..16 (AXI3)
ADDR_START, 32'h10000000, framebuffer base; aligned to BURST_BYTES
CHK_SHIFT, 5, checker square size = 2**CHK_SHIFT pixels

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
enable  in  1  start/continue frame generation
pattern_mode  in  2  0 solid, 1 colour bars, 2 gradient, 3 checker
solid_rgb  in  24  {R,G,B} colour for modes 0 and 3
err_clr  in  1  clears err_sticky
m_axi_awaddr  out  ADDR_W  burst address
m_axi_awlen  out  4  BURST_LEN-1
m_axi_awsize  out  3  clog2(DATA_W/8)
m_axi_awburst  out  2  constant 2'b01
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_W  pixel data
m_axi_wstrb  out  DATA_W/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready
frame_done  out  1  one-cycle pulse, IRQ (rising edge)
err_sticky  out  1  any non-OKAY bresp seen
frame_count  out  16  completed frames, wraps

Behaviour:
- Derived constants:
  - PIX_PER_BEAT = DATA_W/(8*PIX_BYTES)
  - BURST_BYTES = BURST_LEN*DATA_W/8
  - FRAME_BYTES = FRAME_W*FRAME_H*PIX_BYTES
- Elaboration-time checks: FRAME_BYTES % BURST_BYTES == 0, and 4096 % BURST_BYTES == 0, so no burst ever crosses a 4 KB boundary.
- Reset (async, aresetn): all valid/ready/pulse outputs 0, awaddr 0, wdata 0, err_sticky 0, frame_count 0, FSM in IDLE, x/y/addr counters cleared. Reset mid-burst abandons the burst with no recovery attempt.
- Static outputs: awlen, awsize, awburst and wstrb are constant at all times.
- FSM states and transitions:
  - IDLE: when enable=1, latch pattern_mode/solid_rgb, set addr=ADDR_START, x=y=0, go to ADDR. These values stay fixed for the whole frame.
  - ADDR: awvalid=1, awaddr=addr, held stable until awready. On handshake go to DATA.
  - DATA: wvalid=1.
    - Beat accepted on wvalid&wready; beat counter increments.
    - wdata and wlast held stable while wready=0.
    - wlast=1 when beat==BURST_LEN-1; accepting that beat goes to RESP.
    - No AW is issued until the previous B is received (one outstanding burst).
  - RESP: bready=1; on bvalid:
    - non-zero bresp sets err_sticky;
    - addr += BURST_BYTES;
    - if addr+BURST_BYTES == ADDR_START+FRAME_BYTES go to FDONE, else go to ADDR.
  - FDONE: frame_done=1 for exactly one cycle, frame_count++, then go to IDLE. IDLE re-checks enable, so back-to-back frames have a 2-cycle gap.
- enable deassert mid-frame: the current frame completes; the stop takes effect in IDLE.
- Pixel generation:
  - Each beat packs PIX_PER_BEAT pixels, pixel i in bits [i*8*PIX_BYTES +: 8*PIX_BYTES], with lower x in lower bits.
  - x advances by PIX_PER_BEAT per accepted beat; at FRAME_W, x wraps to 0 and y++.
  - Colour of pixel at column px by mode:
    - mode 0: solid_rgb.
    - mode 1: bar index b = px/(FRAME_W/8). Implement with a bar counter compared against multiples of FRAME_W/8; no divider. Colour = {R=b[2]?FF:00, G=b[1]?FF:00, B=b[0]?FF:00}; bar 0 is black, bar 7 is white.
    - mode 2: R=px[7:0], G=y[7:0], B=8'h80.
    - mode 3: if px[CHK_SHIFT]^y[CHK_SHIFT] then ~solid_rgb, else solid_rgb.
  - wdata is registered: the next beat's data is prepared on handshake so wvalid never drops mid-burst.
- err_sticky: set by error bresp, cleared by err_clr. If both occur in the same cycle, set wins.
- frame_count wraps from 16'hFFFF to 0.

Decomposition:
- Shared package afpw_pkg holds:
  - FSM state enum (IDLE, ADDR, DATA, RESP, FDONE);
  - pattern mode constants PAT_SOLID/PAT_BARS/PAT_GRAD/PAT_CHK;
  - AXI constants BURST_INCR and RESP_OKAY.
- One sub-module: afpw_pixel_gen.
  - Holds the x/y/bar counters and pattern logic.
  - Input advance; output beat data.
- The top-level module holds the FSM and the AXI handshakes.

Test Plan:
- Small config FRAME_W=16, FRAME_H=4, BURST_LEN=4, DATA_W=64, mode 0, solid_rgb=24'h123456, slave always ready, enable=1:
  - 8 bursts at awaddr 0x10000000, 0x10000020, ... 0x100000E0;
  - every beat carries 64'hFF125634FF125634;
  - frame_done pulses once, frame_count=1.
- Random awready/wready/bvalid stalls of 0-5 cycles, mode 2:
  - awaddr/wdata/wlast stay stable while stalled;
  - exactly 32 beats are accepted, with wlast on every 4th;
  - pixel (x=5,y=2) = {FF,05,80,02} in the order {8'hFF,R,B,G}.
- Mode 1, FRAME_W=16:
  - pixels x=0..1 are black, x=14..15 are FFFFFF;
  - x=8 (bar 4) is R=FF,G=00,B=00.
- bresp=2'b10 on burst 3:
  - err_sticky=1, the frame still completes;
  - err_clr asserted in the same cycle as a second error leaves err_sticky=1.
- enable deasserted during burst 2: the frame finishes (8 bursts, frame_done pulses), then awvalid stays 0.
- aresetn pulled low mid-DATA beat: awvalid, wvalid, bready and frame_done go 0 immediately; after release with enable=1 the next AW is at 0x10000000.
